// File: rtl/bnn_neuron_sequencer.sv
// Bit-serial XNOR-popcount binary neuron sequencer: one shared activation vector,
// one weight word per neuron pulled over valid/ready, thresholded results packed into y_out.
module bnn_neuron_sequencer #(
    parameter int IN_BITS   = 8,
    parameter int N_NEURONS = 8,
    parameter int CNT_W     = $clog2(IN_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IN_BITS-1:0]   x_in,
    input  logic [CNT_W-1:0]     thr,
    input  logic                 w_valid,
    input  logic [IN_BITS-1:0]   w_data,
    output logic                 w_ready,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] y_out,
    output logic                 y_valid
);

    localparam int IDX_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam int N_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        ACC    = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [IN_BITS-1:0]   x_r;
    logic [IN_BITS-1:0]   w_r;
    logic [CNT_W-1:0]     thr_r;
    logic [CNT_W-1:0]     acc_r;
    logic [IDX_W-1:0]     bit_r;
    logic [N_W-1:0]       n_r;
    logic [N_NEURONS-1:0] y_out_r;
    logic                 y_valid_r;
    logic                 w_ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 xfer_s;
    logic                 match_s;
    logic                 fire_s;

    // Next-state logic and per-cycle datapath terms
    always_comb begin
        state_s = state_r;
        xfer_s  = w_valid && w_ready_r;
        match_s = ~(x_r[bit_r] ^ w_r[bit_r]);
        fire_s  = (acc_r >= thr_r);
        case (state_r)
            IDLE: begin
                if (start) state_s = WAIT_W;
                else       state_s = IDLE;
            end
            WAIT_W: begin
                if (xfer_s) state_s = ACC;
                else        state_s = WAIT_W;
            end
            ACC: begin
                if (bit_r == IDX_W'(IN_BITS - 1)) state_s = DECIDE;
                else                              state_s = ACC;
            end
            DECIDE: begin
                if (n_r == N_W'(N_NEURONS - 1)) state_s = DONE;
                else                            state_s = WAIT_W;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs (outputs track the state being entered)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            x_r       <= '0;
            w_r       <= '0;
            thr_r     <= '0;
            acc_r     <= '0;
            bit_r     <= '0;
            n_r       <= '0;
            y_out_r   <= '0;
            y_valid_r <= 1'b0;
            w_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            w_ready_r <= (state_s == WAIT_W);
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r       <= x_in;
                        thr_r     <= thr;
                        y_out_r   <= '0;
                        y_valid_r <= 1'b0;
                        n_r       <= '0;
                    end
                end
                WAIT_W: begin
                    if (xfer_s) begin
                        w_r   <= w_data;
                        bit_r <= '0;
                        acc_r <= '0;
                    end
                end
                ACC: begin
                    acc_r <= acc_r + CNT_W'(match_s);
                    bit_r <= bit_r + IDX_W'(1);
                end
                DECIDE: begin
                    y_out_r[n_r] <= fire_s;
                    if (n_r == N_W'(N_NEURONS - 1)) y_valid_r <= 1'b1;
                    else                            n_r <= n_r + N_W'(1);
                end
                DONE: begin
                    y_valid_r <= 1'b1;
                end
                default: begin
                    y_valid_r <= y_valid_r;
                end
            endcase
        end
    end

    assign w_ready = w_ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign y_out   = y_out_r;
    assign y_valid = y_valid_r;

endmodule
